everloop_framebuf: RTL
======================

EVERLOOP_FRAMEBUF -- requirements
Module: everloop_framebuf

Interface
REQ-001 Parameter FRAME_BYTES, default 141: bytes per LED frame (addresses 0..FRAME_BYTES-1).
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset, asynchronous and active-low; asserting it (rst=0) immediately resets all state.
REQ-004 wr_en  in  1  host byte-write strobe, one byte per cycle.
REQ-005 wr_addr  in  8  host byte address into the fill bank.
REQ-006 wr_data  in  8  host byte data (G,R,B,W order per LED, as the LED driver expects).
REQ-007 commit  in  1  single-cycle pulse: fill bank complete, request swap.
REQ-008 clear_err  in  1  clears wr_err.
REQ-009 address  in  8  read address from the everloop LED driver.
REQ-010 data_RGB  out  8  display-bank byte at address.
REQ-011 pending  out  1  high while a commit awaits a frame boundary.
REQ-012 wr_err  out  1  sticky error flag.
REQ-013 frame_count  out  8  number of completed swaps, mod 256.

Function
REQ-014 Storage SHALL be two banks of FRAME_BYTES x 8; bank select bit disp marks the display bank, the other is the fill bank.
REQ-015 data_RGB SHALL be a combinational read of display bank at address (zero latency); address >= FRAME_BYTES or disp_valid=0 SHALL yield 8'h00.
REQ-016 Write FSM states: FILL, PENDING, SWAP.
REQ-017 FILL: wr_en with wr_addr < FRAME_BYTES writes wr_data to fill bank at next posedge; commit -> PENDING.
REQ-018 FILL: wr_en with wr_addr >= FRAME_BYTES SHALL write nothing and set wr_err.
REQ-019 wr_en and commit in the same FILL cycle: write SHALL complete, then state -> PENDING.
REQ-020 PENDING: wr_en SHALL be dropped (no bank change) and set wr_err; further commit pulses ignored, no error.
REQ-021 Frame boundary SHALL be detected as address==0 while registered previous address addr_q != 0; addr_q updates every cycle.
REQ-022 PENDING with boundary -> SWAP; boundary seen in FILL or SWAP SHALL be ignored.
REQ-023 SWAP (exactly one cycle): toggle disp, set disp_valid=1, frame_count+1 (8-bit wrap 255->0), -> FILL.
REQ-024 The toggle SHALL take effect on the posedge ending SWAP, i.e. 2 cycles after boundary cycle; the driver's first LD_DATA of the new frame therefore reads the old bank.
REQ-025 pending SHALL equal (state==PENDING || state==SWAP).
REQ-026 clear_err SHALL clear wr_err; a same-cycle error event SHALL win (wr_err stays 1).
REQ-027 Fill bank contents SHALL persist across a swap (new fill bank holds the frame displayed before it; host rewrites fully).

Reset
REQ-028 On rst=0: state=FILL, disp=0, disp_valid=0, addr_q=0, pending=0, wr_err=0, frame_count=0; data_RGB=0.
REQ-029 Bank memory SHALL not be cleared by reset; contents are unobservable until first swap via disp_valid.
REQ-030 Reset mid-PENDING or mid-SWAP SHALL abandon the swap with no bank toggle and no count increment.

Verification
REQ-031 After reset, address swept 0..140 -> data_RGB=00 every cycle; pending=0, frame_count=0.
REQ-032 Write bytes 0..140 with value addr^8'hA5, commit, then address 140->0 -> pending=1 until 2 cycles after boundary; then reading address 5 gives 8'hA0, frame_count=1.
REQ-033 wr_en with wr_addr=200 in FILL -> wr_err=1, no bank change; clear_err -> wr_err=0.
REQ-034 commit, then wr_en addr 3 while pending -> wr_err=1, after swap display byte 3 holds pre-commit value.
REQ-035 wr_en addr 0 data 8'h11 with commit in same cycle -> after swap address 0 reads 8'h11.
REQ-036 257 commit/boundary cycles -> frame_count=1 (wrap); rst=0 during PENDING -> pending=0 same cycle, disp unchanged, data_RGB=00.

Source files
------------

// File: rtl/everloop_framebuf_if.sv
// Host write port and LED-driver read port of the everloop double-buffered frame store.
`timescale 1ns/1ps
interface everloop_framebuf_if;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       clear_err;
    logic [7:0] address;
    logic [7:0] data_RGB;
    logic       pending;
    logic       wr_err;
    logic [7:0] frame_count;

    modport master (
        output wr_en, wr_addr, wr_data, commit, clear_err, address,
        input  data_RGB, pending, wr_err, frame_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, clear_err, address,
        output data_RGB, pending, wr_err, frame_count
    );
endinterface

// File: rtl/everloop_framebuf.sv
// Double-buffered LED frame store: the host fills one bank while the driver reads the other;
// a commit swaps the banks at the next driver frame boundary.
//
//   state   | meaning
//   FILL    | host may write the fill bank; commit requests a swap
//   PENDING | swap requested, waiting for address to wrap to 0; writes are rejected
//   SWAP    | one cycle: flip display bank, mark it valid, bump frame_count
`timescale 1ns/1ps
module everloop_framebuf #(
    parameter int FRAME_BYTES = 141
) (
    input logic               clk,
    input logic               rst,
    everloop_framebuf_if.slave bus
);
    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } state_t;

    localparam logic [8:0] FB_LIM = 9'(FRAME_BYTES);

    state_t     state_q, state_d;
    logic       disp_q, disp_d;
    logic       disp_valid_q, disp_valid_d;
    logic [7:0] addr_q, addr_d;
    logic       wr_err_q, wr_err_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic       mem_we;
    logic       err_evt;
    logic       boundary;
    logic       wr_in_range;
    logic       rd_in_range;

    // Banks carry no reset; disp_valid hides their power-up contents.
    logic [7:0] bank_mem [2][FRAME_BYTES];

    assign wr_in_range = ({1'b0, bus.wr_addr} < FB_LIM);
    assign rd_in_range = ({1'b0, bus.address} < FB_LIM);
    assign boundary    = (bus.address == 8'd0) && (addr_q != 8'd0);

    always_comb begin
        state_d       = state_q;
        disp_d        = disp_q;
        disp_valid_d  = disp_valid_q;
        frame_count_d = frame_count_q;
        addr_d        = bus.address;
        mem_we        = 1'b0;
        err_evt       = 1'b0;

        case (state_q)
            FILL: begin
                if (bus.wr_en) begin
                    if (wr_in_range) mem_we  = 1'b1;
                    else             err_evt = 1'b1;
                end
                if (bus.commit) state_d = PENDING;
            end
            PENDING: begin
                if (bus.wr_en) err_evt = 1'b1;
                if (boundary)  state_d = SWAP;
            end
            SWAP: begin
                // The fill bank is about to go on display, so late writes are refused here too.
                if (bus.wr_en) err_evt = 1'b1;
                disp_d        = ~disp_q;
                disp_valid_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
                state_d       = FILL;
            end
            default: state_d = FILL;
        endcase

        if (err_evt)            wr_err_d = 1'b1;
        else if (bus.clear_err) wr_err_d = 1'b0;
        else                    wr_err_d = wr_err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FILL;
            disp_q        <= 1'b0;
            disp_valid_q  <= 1'b0;
            addr_q        <= 8'd0;
            wr_err_q      <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            disp_q        <= disp_d;
            disp_valid_q  <= disp_valid_d;
            addr_q        <= addr_d;
            wr_err_q      <= wr_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) bank_mem[~disp_q][bus.wr_addr] <= bus.wr_data;
    end

    assign bus.data_RGB    = (disp_valid_q && rd_in_range) ? bank_mem[disp_q][bus.address] : 8'h00;
    assign bus.pending     = (state_q == PENDING) || (state_q == SWAP);
    assign bus.wr_err      = wr_err_q;
    assign bus.frame_count = frame_count_q;
endmodule
